// File: rtl/fwd_ctrl_stage_if.sv
// Purpose : bundles the ID-stage request, write-back data and EX-side results of fwd_ctrl_stage.
// Latency : none; this is wiring only.
// Backpr. : none here; stall/flush are global freezes, load_use_stall asks upstream to hold.
//
// Ports (slave = the stage itself, master = whoever drives the pipeline):
//   stall, flush                      pipeline control into the stage
//   id_valid/regwrite/memread         ID instruction attributes
//   id_rs1/rs2/rd, id_rs1/rs2_data    ID register indices and register-file read data
//   wb_data                           value being written back this cycle
//   ex_*                              registered ID/EX contents
//   fwd_a_sel/fwd_b_sel               operand mux selects (00 ID/EX, 01 EX/MEM, 10 MEM/WB)
//   load_use_stall                    hold PC and IF/ID for one cycle
interface fwd_ctrl_stage_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            flush;
    logic            id_valid;
    logic            id_regwrite;
    logic            id_memread;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] wb_data;

    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [4:0]      ex_rd;
    logic            ex_regwrite;
    logic            ex_memread;
    logic            ex_valid;
    logic [1:0]      fwd_a_sel;
    logic [1:0]      fwd_b_sel;
    logic            load_use_stall;

    modport slave (
        input  stall, flush,
        input  id_valid, id_regwrite, id_memread,
        input  id_rs1, id_rs2, id_rd,
        input  id_rs1_data, id_rs2_data, wb_data,
        output ex_rs1_data, ex_rs2_data, ex_rd,
        output ex_regwrite, ex_memread, ex_valid,
        output fwd_a_sel, fwd_b_sel, load_use_stall
    );

    modport master (
        output stall, flush,
        output id_valid, id_regwrite, id_memread,
        output id_rs1, id_rs2, id_rd,
        output id_rs1_data, id_rs2_data, wb_data,
        input  ex_rs1_data, ex_rs2_data, ex_rd,
        input  ex_regwrite, ex_memread, ex_valid,
        input  fwd_a_sel, fwd_b_sel, load_use_stall
    );
endinterface

// File: rtl/fwd_ctrl_stage.sv
// Purpose : ID/EX register plus EX/MEM and MEM/WB tracking slots driving operand forwarding and load-use detection.
// Latency : ID instruction appears on ex_* one edge after capture; selects and load_use_stall are combinational.
// Backpr. : stall freezes every slot; flush or a load-use hazard injects a bubble into ID/EX while older slots advance.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset, overrides stall and flush
//   ctrl_io  fwd_ctrl_stage_if.slave bundle (ID inputs, WB data, EX outputs, selects, load_use_stall)
module fwd_ctrl_stage #(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    fwd_ctrl_stage_if.slave    ctrl_io
);

    localparam logic [1:0] SEL_IDEX  = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;

    typedef struct packed {
        logic            vld;
        logic            regwrite;
        logic            memread;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1_dat;
        logic [XLEN-1:0] rs2_dat;
    } idex_t;

    // The load flag is only consumed while the instruction sits in ID/EX
    // (load-use detection); from EX/MEM onward a load is just another
    // writer whose result is forwarded like any ALU result.
    typedef struct packed {
        logic       vld;
        logic       regwrite;
        logic [4:0] rd;
    } exmem_t;

    typedef struct packed {
        logic       vld;
        logic       regwrite;
        logic [4:0] rd;
    } memwb_t;

    idex_t  idex_q,  idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;

    logic   load_use;
    logic   wb_hit_rs1;
    logic   wb_hit_rs2;

    // x0 is hard-wired zero, so a slot naming it as destination never
    // produces a value worth forwarding.
    function automatic logic exmem_writes(input exmem_t s, input logic [4:0] r);
        return s.vld && s.regwrite && (s.rd == r) && (r != 5'd0);
    endfunction

    function automatic logic memwb_writes(input memwb_t s, input logic [4:0] r);
        return s.vld && s.regwrite && (s.rd == r) && (r != 5'd0);
    endfunction

    // The younger result (EX/MEM) is the architecturally newest value, so it
    // wins when both downstream slots target the same register.
    function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                           input exmem_t  em,
                                           input memwb_t  mw);
        logic [1:0] sel;
        sel = SEL_IDEX;
        if (exmem_writes(em, r)) begin
            sel = SEL_EXMEM;
        end else if (memwb_writes(mw, r)) begin
            sel = SEL_MEMWB;
        end
        return sel;
    endfunction

    // ------------------------------------------------------------------
    // Hazard detection and forwarding selects (from registered state,
    // plus the ID indices for the load-use check)
    // ------------------------------------------------------------------
    always_comb begin
        load_use = 1'b0;
        if (ctrl_io.id_valid && idex_q.vld && idex_q.memread && (idex_q.rd != 5'd0)) begin
            load_use = (idex_q.rd == ctrl_io.id_rs1) || (idex_q.rd == ctrl_io.id_rs2);
        end
    end

    // The register file is written at the same edge ID/EX captures, so its
    // read port still returns the old value; take the write-back value instead.
    assign wb_hit_rs1 = memwb_writes(memwb_q, ctrl_io.id_rs1);
    assign wb_hit_rs2 = memwb_writes(memwb_q, ctrl_io.id_rs2);

    // ------------------------------------------------------------------
    // Next-state: stall > flush/load-use bubble > normal advance
    // (reset takes priority over all of these in the register process)
    // ------------------------------------------------------------------
    always_comb begin
        idex_d  = idex_q;
        exmem_d = exmem_q;
        memwb_d = memwb_q;

        if (!ctrl_io.stall) begin
            exmem_d.vld      = idex_q.vld;
            exmem_d.regwrite = idex_q.regwrite;
            exmem_d.rd       = idex_q.rd;

            memwb_d.vld      = exmem_q.vld;
            memwb_d.regwrite = exmem_q.regwrite;
            memwb_d.rd       = exmem_q.rd;

            if (ctrl_io.flush || load_use) begin
                idex_d = '0;
            end else begin
                idex_d.vld      = ctrl_io.id_valid;
                idex_d.regwrite = ctrl_io.id_regwrite;
                idex_d.memread  = ctrl_io.id_memread;
                idex_d.rs1      = ctrl_io.id_rs1;
                idex_d.rs2      = ctrl_io.id_rs2;
                idex_d.rd       = ctrl_io.id_rd;
                idex_d.rs1_dat  = wb_hit_rs1 ? ctrl_io.wb_data : ctrl_io.id_rs1_data;
                idex_d.rs2_dat  = wb_hit_rs2 ? ctrl_io.wb_data : ctrl_io.id_rs2_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ctrl_io.ex_rs1_data    = idex_q.rs1_dat;
    assign ctrl_io.ex_rs2_data    = idex_q.rs2_dat;
    assign ctrl_io.ex_rd          = idex_q.rd;
    assign ctrl_io.ex_regwrite    = idex_q.regwrite;
    assign ctrl_io.ex_memread     = idex_q.memread;
    assign ctrl_io.ex_valid       = idex_q.vld;
    assign ctrl_io.fwd_a_sel      = fwd_sel(idex_q.rs1, exmem_q, memwb_q);
    assign ctrl_io.fwd_b_sel      = fwd_sel(idex_q.rs2, exmem_q, memwb_q);
    assign ctrl_io.load_use_stall = load_use;

    // The mux encoding 11 has no source behind it.
    a_sel_a_legal: assert property (@(posedge clk) disable iff (rst) ctrl_io.fwd_a_sel != 2'b11);
    a_sel_b_legal: assert property (@(posedge clk) disable iff (rst) ctrl_io.fwd_b_sel != 2'b11);

endmodule

// File: tb/tb_fwd_ctrl_stage.sv
// Purpose : directed scoreboard bench for fwd_ctrl_stage.
// Latency : expectations are queued per cycle and checked on the falling edge.
// Backpr. : none; stimulus and checking run as independent processes.
module tb_fwd_ctrl_stage;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fwd_ctrl_stage_if #(.XLEN(XLEN)) bus ();

    fwd_ctrl_stage #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_io (bus)
    );

    typedef struct packed {
        logic        v;
        logic        rw;
        logic        mr;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        lus;
        logic [15:0] tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want, input int c);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got 0x%h, expected 0x%h", nm, c, act, want);
        end
    endtask

    // Monitor: every cycle that has a queued expectation is compared.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("ex_valid",       32'(bus.ex_valid),       32'(mon_e.v),   int'(mon_e.tag));
            chk("ex_regwrite",    32'(bus.ex_regwrite),    32'(mon_e.rw),  int'(mon_e.tag));
            chk("ex_memread",     32'(bus.ex_memread),     32'(mon_e.mr),  int'(mon_e.tag));
            chk("ex_rd",          32'(bus.ex_rd),          32'(mon_e.rd),  int'(mon_e.tag));
            chk("ex_rs1_data",    bus.ex_rs1_data,         mon_e.d1,       int'(mon_e.tag));
            chk("ex_rs2_data",    bus.ex_rs2_data,         mon_e.d2,       int'(mon_e.tag));
            chk("fwd_a_sel",      32'(bus.fwd_a_sel),      32'(mon_e.fa),  int'(mon_e.tag));
            chk("fwd_b_sel",      32'(bus.fwd_b_sel),      32'(mon_e.fb),  int'(mon_e.tag));
            chk("load_use_stall", 32'(bus.load_use_stall), 32'(mon_e.lus), int'(mon_e.tag));
        end
    end

    task automatic drv(input logic r, input logic s, input logic f,
                       input logic v, input logic rw, input logic mr,
                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       input logic [31:0] da, input logic [31:0] db, input logic [31:0] wb);
        rst             = r;
        bus.stall       = s;
        bus.flush       = f;
        bus.id_valid    = v;
        bus.id_regwrite = rw;
        bus.id_memread  = mr;
        bus.id_rs1      = a;
        bus.id_rs2      = b;
        bus.id_rd       = d;
        bus.id_rs1_data = da;
        bus.id_rs2_data = db;
        bus.wb_data     = wb;
    endtask

    task automatic idle(input logic r, input logic s, input logic f, input logic [31:0] wb);
        drv(r, s, f, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, wb);
    endtask

    task automatic expect_o(input logic v, input logic rw, input logic mr, input logic [4:0] rd,
                            input logic [31:0] d1, input logic [31:0] d2,
                            input logic [1:0] fa, input logic [1:0] fb, input logic lus);
        exp_t e;
        e.v   = v;
        e.rw  = rw;
        e.mr  = mr;
        e.rd  = rd;
        e.d1  = d1;
        e.d2  = d2;
        e.fa  = fa;
        e.fb  = fb;
        e.lus = lus;
        e.tag = 16'(cyc);
        exp_q.push_back(e);
    endtask

    task automatic zero_o();
        expect_o(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        // C0: reset
        idle(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        // C1: reset state; I1 writes x5
        drv(0,0,0, 1,1,0, 5'd1, 5'd2, 5'd5, 32'h11, 32'h12, 32'h0);  zero_o();  tick();
        // C2: I1 in EX; I2 reads x5
        drv(0,0,0, 1,1,0, 5'd5, 5'd6, 5'd8, 32'h21, 32'h22, 32'h0);
        expect_o(1,1,0, 5'd5, 32'h11, 32'h12, 2'b00, 2'b00, 0);  tick();
        // C3: I2 in EX, I1 in EX/MEM -> A from EX/MEM; I3 reads x5 as rs2
        drv(0,0,0, 1,1,0, 5'd4, 5'd5, 5'd10, 32'h31, 32'h32, 32'h0);
        expect_o(1,1,0, 5'd8, 32'h21, 32'h22, 2'b01, 2'b00, 0);  tick();
        // C4: I3 in EX, I1 in MEM/WB -> B from MEM/WB
        idle(0,0,0, 32'h0);
        expect_o(1,1,0, 5'd10, 32'h31, 32'h32, 2'b00, 2'b10, 0);  tick();
        // C5..C8: two writers of x7 back to back, then a reader
        drv(0,0,0, 1,1,0, 5'd0, 5'd0, 5'd7, 32'h51, 32'h52, 32'h0);  zero_o();  tick();
        drv(0,0,0, 1,1,0, 5'd0, 5'd0, 5'd7, 32'h61, 32'h62, 32'h0);
        expect_o(1,1,0, 5'd7, 32'h51, 32'h52, 2'b00, 2'b00, 0);  tick();
        drv(0,0,0, 1,1,0, 5'd7, 5'd3, 5'd11, 32'h71, 32'h72, 32'h0);
        expect_o(1,1,0, 5'd7, 32'h61, 32'h62, 2'b00, 2'b00, 0);  tick();
        idle(0,0,0, 32'h0);
        expect_o(1,1,0, 5'd11, 32'h71, 32'h72, 2'b01, 2'b00, 0);  tick();
        // C9: load into x3
        drv(0,0,0, 1,1,1, 5'd1, 5'd2, 5'd3, 32'h91, 32'h92, 32'h0);  zero_o();  tick();
        // C10: load in EX, consumer reads x3 as rs2 -> load-use
        drv(0,0,0, 1,1,0, 5'd4, 5'd3, 5'd12, 32'hA1, 32'hA2, 32'h0);
        expect_o(1,1,1, 5'd3, 32'h91, 32'h92, 2'b00, 2'b00, 1);  tick();
        // C11: bubble in EX, consumer held in ID, no second stall
        drv(0,0,0, 1,1,0, 5'd4, 5'd3, 5'd12, 32'hA1, 32'hA2, 32'h0);  zero_o();  tick();
        // C12: consumer in EX, load now in MEM/WB
        idle(0,0,0, 32'h0);
        expect_o(1,1,0, 5'd12, 32'hA1, 32'hA2, 2'b00, 2'b10, 0);  tick();
        // C13..C15: load/write to x0, reader of x0
        drv(0,0,0, 1,1,1, 5'd0, 5'd0, 5'd0, 32'hB1, 32'hB2, 32'h0);  zero_o();  tick();
        drv(0,0,0, 1,1,0, 5'd0, 5'd0, 5'd13, 32'hC1, 32'hC2, 32'h0);
        expect_o(1,1,1, 5'd0, 32'hB1, 32'hB2, 2'b00, 2'b00, 0);  tick();
        idle(0,0,0, 32'h0);
        expect_o(1,1,0, 5'd13, 32'hC1, 32'hC2, 2'b00, 2'b00, 0);  tick();
        // C16: MEM/WB writes x0; rs1=x0 capture must not take wb_data
        drv(0,0,0, 1,1,0, 5'd0, 5'd0, 5'd9, 32'h16, 32'h26, 32'hFFFF0000);  zero_o();  tick();
        // C17: MEM/WB writes x13; rs2=13 capture takes wb_data
        drv(0,0,0, 1,1,0, 5'd2, 5'd13, 5'd14, 32'h17, 32'h27, 32'h13131313);
        expect_o(1,1,0, 5'd9, 32'h16, 32'h26, 2'b00, 2'b00, 0);  tick();
        idle(0,0,0, 32'h0);
        expect_o(1,1,0, 5'd14, 32'h17, 32'h13131313, 2'b00, 2'b00, 0);  tick();
        // C19: MEM/WB writes x9 with 0xDEADBEEF; both operands read x9
        drv(0,0,0, 1,1,0, 5'd9, 5'd9, 5'd15, 32'h0, 32'h55, 32'hDEADBEEF);  zero_o();  tick();
        idle(0,0,0, 32'h0);
        expect_o(1,1,0, 5'd15, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 2'b00, 0);  tick();
        // C21: A reads x15 (writer moves to MEM/WB)
        drv(0,0,0, 1,1,0, 5'd15, 5'd0, 5'd16, 32'hA0, 32'hA4, 32'h0);  zero_o();  tick();
        // C22,C23: stall holds everything
        drv(0,1,0, 1,1,1, 5'd1, 5'd2, 5'd17, 32'hB0, 32'hB4, 32'h0);
        expect_o(1,1,0, 5'd16, 32'hA0, 32'hA4, 2'b10, 2'b00, 0);  tick();
        drv(0,1,0, 1,1,1, 5'd1, 5'd2, 5'd17, 32'hB0, 32'hB4, 32'h0);
        expect_o(1,1,0, 5'd16, 32'hA0, 32'hA4, 2'b10, 2'b00, 0);  tick();
        // C24: flush; A advances to EX/MEM, ID/EX becomes a bubble
        drv(0,0,1, 1,1,1, 5'd1, 5'd2, 5'd17, 32'hB0, 32'hB4, 32'h0);
        expect_o(1,1,0, 5'd16, 32'hA0, 32'hA4, 2'b10, 2'b00, 0);  tick();
        drv(0,0,0, 1,1,0, 5'd16, 5'd16, 5'd18, 32'hC0, 32'hC4, 32'h0);  zero_o();  tick();
        // C26: C in EX sees A (x16) in MEM/WB on both operands
        drv(0,0,0, 1,1,1, 5'd0, 5'd0, 5'd19, 32'hD0, 32'hD4, 32'h0);
        expect_o(1,1,0, 5'd18, 32'hC0, 32'hC4, 2'b10, 2'b10, 0);  tick();
        // C27: load in EX, hazard present, reset asserted together with stall
        drv(1,1,0, 1,1,0, 5'd19, 5'd18, 5'd20, 32'hE0, 32'hE4, 32'h0);
        expect_o(1,1,1, 5'd19, 32'hD0, 32'hD4, 2'b00, 2'b00, 1);  tick();
        // C28: reset won over stall; everything cleared
        drv(0,1,0, 1,1,0, 5'd19, 5'd18, 5'd20, 32'hE0, 32'hE4, 32'h0);  zero_o();  tick();
        idle(0,0,0, 32'h0);  zero_o();  tick();

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
